buffer_lru_reader: RTL and testbench

Read-side companion to the LRU value buffer. On a rising edge of `start_i` it snapshots the buffer's flat data array and its presence mask. It then streams every present entry, in ascending slot index, over a valid/ready handshake. Typical consumers are a serial transmitter or a display scanner. It never modifies the buffer; it only consumes the buffer's `buf_array`/`buf_pres_array` outputs.

---
 rtl/buffer_lru_reader.sv | 144 ++++++++++++++
 tb/tb_buffer_lru_reader.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/buffer_lru_reader.sv
// Read-side companion to the LRU value buffer: snapshots the buffer on a start
// rise and streams every present slot, lowest index first, over valid/ready.
module buffer_lru_reader #(
  parameter int BUF_WIDTH = 16,
  parameter int BUF_SIZE  = 8,
  localparam int IDX_W    = $clog2(BUF_SIZE)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          start_i,
  input  logic [BUF_SIZE*BUF_WIDTH-1:0] buf_array_i,
  input  logic [BUF_SIZE-1:0]           buf_pres_array_i,
  output logic [BUF_WIDTH-1:0]          val_o,
  output logic [IDX_W-1:0]              idx_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic                          last_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [IDX_W:0]                count_o
);

  typedef enum logic [1:0] {IDLE, SCAN, SEND, DONE} state_e;

  state_e                        state_q, state_d;
  logic                          start_q;
  logic [BUF_SIZE*BUF_WIDTH-1:0] snap_data_q, snap_data_d;
  logic [BUF_SIZE-1:0]           snap_pres_q, snap_pres_d;
  logic [IDX_W-1:0]              ptr_q, ptr_d;
  logic [BUF_WIDTH-1:0]          val_q, val_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic                          valid_q, valid_d;
  logic                          last_q, last_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;
  logic [IDX_W:0]                count_q, count_d;
  logic                          rise;

  // True when any slot strictly above p is present in mask m.
  function automatic logic any_above(input logic [BUF_SIZE-1:0] m,
                                     input logic [IDX_W-1:0] p);
    logic r;
    r = 1'b0;
    for (int k = 0; k < BUF_SIZE; k++) begin
      if ((k > int'(p)) && m[k]) r = 1'b1;
    end
    return r;
  endfunction

  assign rise = start_i && !start_q;

  always_comb begin
    state_d     = state_q;
    snap_data_d = snap_data_q;
    snap_pres_d = snap_pres_q;
    ptr_d       = ptr_q;
    val_d       = val_q;
    idx_d       = idx_q;
    valid_d     = valid_q;
    last_d      = last_q;
    count_d     = count_q;
    unique case (state_q)
      IDLE: begin
        // Rises seen outside IDLE are simply dropped.
        if (rise) begin
          snap_data_d = buf_array_i;
          snap_pres_d = buf_pres_array_i;
          ptr_d       = '0;
          count_d     = '0;
          state_d     = SCAN;
        end
      end
      SCAN: begin
        if (snap_pres_q[ptr_q]) begin
          val_d   = snap_data_q[int'(ptr_q)*BUF_WIDTH +: BUF_WIDTH];
          idx_d   = ptr_q;
          valid_d = 1'b1;
          last_d  = !any_above(snap_pres_q, ptr_q);
          state_d = SEND;
        end else if (ptr_q == IDX_W'(BUF_SIZE - 1)) begin
          state_d = DONE;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      SEND: begin
        if (ready_i) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          count_d = count_q + 1'b1;
          if (last_q) begin
            state_d = DONE;
          end else begin
            ptr_d   = ptr_q + 1'b1;
            state_d = SCAN;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SCAN) || (state_d == SEND);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      start_q     <= 1'b1;
      snap_data_q <= '0;
      snap_pres_q <= '0;
      ptr_q       <= '0;
      val_q       <= '0;
      idx_q       <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_i;
      snap_data_q <= snap_data_d;
      snap_pres_q <= snap_pres_d;
      ptr_q       <= ptr_d;
      val_q       <= val_d;
      idx_q       <= idx_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      count_q     <= count_d;
    end
  end

  assign val_o   = val_q;
  assign idx_o   = idx_q;
  assign valid_o = valid_q;
  assign last_o  = last_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign count_o = count_q;

endmodule

// File: tb/tb_buffer_lru_reader.sv
// Directed bench for buffer_lru_reader: one task per scenario, inline checks.
module tb_buffer_lru_reader;

  localparam int W = 16;
  localparam int N = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start_i;
  logic [N*W-1:0] buf_array;
  logic [N-1:0]   pres;
  logic [W-1:0]   val_o;
  logic [2:0]     idx_o;
  logic           valid_o;
  logic           ready_i;
  logic           last_o;
  logic           busy_o;
  logic           done_o;
  logic [3:0]     count_o;

  int n_checks = 0;
  int n_pass   = 0;

  // Per-pass observations filled in by run_pass.
  int           n_xfer, n_done, done_c, busy_cycles, busy_after, unstable, first_valid_c;
  int           x_idx [N];
  logic [W-1:0] x_val [N];
  logic         x_last[N];

  buffer_lru_reader #(.BUF_WIDTH(W), .BUF_SIZE(N)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_i), .buf_array_i(buf_array),
    .buf_pres_array_i(pres), .val_o(val_o), .idx_o(idx_o), .valid_o(valid_o),
    .ready_i(ready_i), .last_o(last_o), .busy_o(busy_o), .done_o(done_o),
    .count_o(count_o)
  );

  always #5 clk = ~clk;

  // Raise start, then watch 60 cycles; consumer stalls stall_n cycles per offer.
  task automatic run_pass(input int stall_n, input bit mutate);
    int st;
    logic [W-1:0] hv;
    logic [2:0] hi;
    logic hl;
    n_xfer = 0; n_done = 0; done_c = -1; busy_cycles = 0; busy_after = 0;
    unstable = 0; first_valid_c = -1; st = 0; hv = '0; hi = '0; hl = 1'b0;
    start_i = 1'b0;
    ready_i = (stall_n == 0);
    @(negedge clk);
    start_i = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (mutate && c == 2) begin buf_array = '1; pres = '1; end
      if (mutate && c == 3) start_i = 1'b0;
      if (mutate && c == 5) start_i = 1'b1;
      if (busy_o) begin
        if (n_done == 0) busy_cycles++;
        else busy_after++;
      end
      if (done_o) begin
        if (n_done == 0) done_c = c;
        n_done++;
      end
      if (valid_o) begin
        if (first_valid_c < 0) first_valid_c = c;
        if (st == 0) begin hv = val_o; hi = idx_o; hl = last_o; end
        else if (val_o !== hv || idx_o !== hi || last_o !== hl) unstable++;
        if (st >= stall_n) begin
          ready_i = 1'b1;
          if (n_xfer < N) begin
            x_idx[n_xfer] = int'(idx_o); x_val[n_xfer] = val_o; x_last[n_xfer] = last_o;
          end
          n_xfer++;
          st = 0;
        end else begin
          ready_i = 1'b0;
          st++;
        end
      end else begin
        ready_i = (stall_n == 0);
      end
    end
    start_i = 1'b0;
    ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_i = 1'b0; ready_i = 1'b0; buf_array = '0; pres = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (valid_o !== 1'b0) $display("FAIL reset_valid got=%b exp=0", valid_o); else n_pass++;
    n_checks++; if (busy_o !== 1'b0 || done_o !== 1'b0) $display("FAIL reset_busy_done got=%b%b exp=00", busy_o, done_o); else n_pass++;
    n_checks++; if (count_o !== 4'd0) $display("FAIL reset_count got=%0d exp=0", count_o); else n_pass++;
    n_checks++; if (val_o !== '0 || idx_o !== '0 || last_o !== 1'b0) $display("FAIL reset_data got=%h/%0d/%b exp=0/0/0", val_o, idx_o, last_o); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_empty();
    pres = 8'h00;
    for (int k = 0; k < N; k++) buf_array[k*W +: W] = 16'h5000 + 16'(k);
    run_pass(0, 1'b0);
    n_checks++; if (n_xfer !== 0 || first_valid_c !== -1) $display("FAIL empty_valid got=%0d offers exp=0", n_xfer); else n_pass++;
    n_checks++; if (n_done !== 1) $display("FAIL empty_done_count got=%0d exp=1", n_done); else n_pass++;
    n_checks++; if (done_c !== 8) $display("FAIL empty_done_time got=%0d exp=8", done_c); else n_pass++;
    n_checks++; if (busy_cycles !== 8) $display("FAIL empty_busy_cycles got=%0d exp=8", busy_cycles); else n_pass++;
    n_checks++; if (count_o !== 4'd0) $display("FAIL empty_count got=%0d exp=0", count_o); else n_pass++;
  endtask

  task automatic test_full();
    pres = 8'hFF;
    for (int k = 0; k < N; k++) buf_array[k*W +: W] = 16'h1000 + 16'(k);
    run_pass(0, 1'b0);
    n_checks++; if (n_xfer !== 8) $display("FAIL full_xfers got=%0d exp=8", n_xfer); else n_pass++;
    n_checks++; if (first_valid_c !== 1) $display("FAIL full_first_valid got=%0d exp=1", first_valid_c); else n_pass++;
    for (int k = 0; k < N; k++) begin
      n_checks++;
      if (x_idx[k] !== k || x_val[k] !== 16'h1000 + 16'(k) || x_last[k] !== (k == N - 1))
        $display("FAIL full_xfer%0d got=%0d/%h/%b exp=%0d/%h/%b", k, x_idx[k], x_val[k], x_last[k],
                 k, 16'h1000 + 16'(k), (k == N - 1));
      else n_pass++;
    end
    n_checks++; if (count_o !== 4'd8) $display("FAIL full_count got=%0d exp=8", count_o); else n_pass++;
    n_checks++; if (n_done !== 1) $display("FAIL full_done got=%0d exp=1", n_done); else n_pass++;
  endtask

  task automatic load_sparse();
    buf_array = '0;
    buf_array[0*W +: W] = 16'hAAAA;
    buf_array[2*W +: W] = 16'hBBBB;
    buf_array[5*W +: W] = 16'hCCCC;
    buf_array[3*W +: W] = 16'hDEAD;
    pres = 8'b0010_0101;
  endtask

  task automatic check_sparse(input string tag);
    n_checks++; if (n_xfer !== 3) $display("FAIL %s_xfers got=%0d exp=3", tag, n_xfer); else n_pass++;
    n_checks++;
    if (x_idx[0] !== 0 || x_val[0] !== 16'hAAAA || x_last[0] !== 1'b0)
      $display("FAIL %s_xfer0 got=%0d/%h/%b exp=0/aaaa/0", tag, x_idx[0], x_val[0], x_last[0]);
    else n_pass++;
    n_checks++;
    if (x_idx[1] !== 2 || x_val[1] !== 16'hBBBB || x_last[1] !== 1'b0)
      $display("FAIL %s_xfer1 got=%0d/%h/%b exp=2/bbbb/0", tag, x_idx[1], x_val[1], x_last[1]);
    else n_pass++;
    n_checks++;
    if (x_idx[2] !== 5 || x_val[2] !== 16'hCCCC || x_last[2] !== 1'b1)
      $display("FAIL %s_xfer2 got=%0d/%h/%b exp=5/cccc/1", tag, x_idx[2], x_val[2], x_last[2]);
    else n_pass++;
    n_checks++; if (count_o !== 4'd3) $display("FAIL %s_count got=%0d exp=3", tag, count_o); else n_pass++;
    n_checks++; if (n_done !== 1) $display("FAIL %s_done got=%0d exp=1", tag, n_done); else n_pass++;
  endtask

  task automatic test_stall();
    load_sparse();
    run_pass(3, 1'b0);
    check_sparse("stall");
    n_checks++; if (unstable !== 0) $display("FAIL stall_stable got=%0d changes exp=0", unstable); else n_pass++;
  endtask

  task automatic test_isolation();
    load_sparse();
    run_pass(0, 1'b1);
    check_sparse("iso");
    n_checks++; if (busy_after !== 0) $display("FAIL iso_no_second_pass got=%0d busy cycles exp=0", busy_after); else n_pass++;
  endtask

  task automatic test_start_through_reset();
    int busy_seen;
    busy_seen = 0;
    pres = 8'hFF;
    start_i = 1'b1;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (busy_o || valid_o) busy_seen++;
    end
    n_checks++; if (busy_seen !== 0) $display("FAIL held_start_pass got=%0d busy cycles exp=0", busy_seen); else n_pass++;
    load_sparse();
    run_pass(0, 1'b0);
    check_sparse("restart");
  endtask

  task automatic test_reset_mid_send();
    int guard;
    buf_array = '0;
    buf_array[0*W +: W] = 16'h1111;
    buf_array[1*W +: W] = 16'h2222;
    pres = 8'b0000_0011;
    start_i = 1'b0; ready_i = 1'b0;
    @(negedge clk); start_i = 1'b1;
    guard = 0;
    while (!(valid_o && idx_o == 3'd1) && guard < 40) begin
      @(negedge clk);
      ready_i = valid_o && (idx_o == 3'd0);
      guard++;
    end
    ready_i = 1'b0;
    n_checks++; if (guard >= 40) $display("FAIL midrst_reach_send got=timeout exp=offer idx1"); else n_pass++;
    n_checks++; if (count_o !== 4'd1) $display("FAIL midrst_pre_count got=%0d exp=1", count_o); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (valid_o !== 1'b0 || busy_o !== 1'b0) $display("FAIL midrst_async got=%b%b exp=00", valid_o, busy_o); else n_pass++;
    n_checks++; if (count_o !== 4'd0 || done_o !== 1'b0) $display("FAIL midrst_count_done got=%0d/%b exp=0/0", count_o, done_o); else n_pass++;
    start_i = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < N; k++) buf_array[k*W +: W] = 16'h1000 + 16'(k);
    pres = 8'hFF;
    run_pass(0, 1'b0);
    n_checks++; if (n_xfer !== 8 || count_o !== 4'd8) $display("FAIL midrst_rerun got=%0d/%0d exp=8/8", n_xfer, count_o); else n_pass++;
    n_checks++;
    if (x_idx[7] !== 7 || x_val[7] !== 16'h1007 || x_last[7] !== 1'b1)
      $display("FAIL midrst_rerun_last got=%0d/%h/%b exp=7/1007/1", x_idx[7], x_val[7], x_last[7]);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_empty();
    test_full();
    test_stall();
    test_isolation();
    test_start_through_reset();
    test_reset_mid_send();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
